// File: rtl/risc_reset_pkg.sv
// Shared encodings for the RISC_PROC reset sequencer: FSM states, reset cause
// codes and a saturating counter helper.
package risc_reset_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_ASSERT  = 2'b00,
        ST_RELEASE = 2'b01,
        ST_RUN     = 2'b10
    } seq_state_t;

    // Cause of the most recent reset sequence, as seen on reset_cause.
    typedef enum logic [1:0] {
        CAUSE_EXT = 2'b00,
        CAUSE_SW  = 2'b01,
        CAUSE_WDT = 2'b10
    } reset_cause_t;

    localparam int unsigned COUNT_WIDTH = 8;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
        logic [COUNT_WIDTH-1:0] result;
        if (value == COUNT_MAX) begin
            result = value;
        end else begin
            result = value + COUNT_WIDTH'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/wdt_counter.sv
// Watchdog counter: counts enabled, un-kicked cycles and raises a one-cycle
// expire pulse on the cycle the count would reach WDT_TIMEOUT.
module wdt_counter #(
    parameter int unsigned WDT_WIDTH   = 16,
    parameter int unsigned WDT_TIMEOUT = 50000
) (
    input  logic i_clock,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_kick,
    output logic o_expire
);

    localparam logic [WDT_WIDTH-1:0] CNT_LAST = WDT_WIDTH'(WDT_TIMEOUT - 1);
    localparam logic [WDT_WIDTH-1:0] CNT_ONE  = WDT_WIDTH'(1);

    logic [WDT_WIDTH-1:0] r_count;
    logic                 w_counting;
    logic                 w_expire;

    // A kick or a disabled watchdog suppresses expiry in the very same cycle.
    assign w_counting = i_enable && !i_kick && !i_clear;
    assign w_expire   = w_counting && (r_count == CNT_LAST);
    assign o_expire   = w_expire;

    // Count enabled cycles; anything that stops counting or fires returns to zero.
    always_ff @(posedge i_clock) begin
        if (!w_counting || w_expire) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_ONE;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Reset controller for the RISC_PROC core domains. Holds every domain in reset
// after any trigger (external, software or watchdog), then releases domains in
// index order with a fixed stagger and reports why and how often it happened.
module reset_sequencer
    import risc_reset_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS  = 4,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned STAGGER      = 2,
    parameter int unsigned WDT_WIDTH    = 16,
    parameter int unsigned WDT_TIMEOUT  = 50000
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_sw_reset_req,
    input  logic                   i_wdt_enable,
    input  logic                   i_wdt_kick,
    output logic [NUM_DOMAINS-1:0] o_domain_reset,
    output logic                   o_all_released,
    output logic [1:0]             o_reset_cause,
    output logic [7:0]             o_reset_count
);

    localparam int unsigned HOLD_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int unsigned STAG_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int unsigned IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PULSE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER - 1);
    localparam logic [STAG_W-1:0] STAG_ONE  = STAG_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

    seq_state_t             r_state;
    logic [HOLD_W-1:0]      r_hold;
    logic [STAG_W-1:0]      r_stag;
    logic [IDX_W-1:0]       r_idx;
    logic [NUM_DOMAINS-1:0] r_domain_reset;
    logic                   r_all_released;
    reset_cause_t           r_reset_cause;
    logic [7:0]             r_reset_count;

    logic w_wdt_clear;
    logic w_wdt_expire;

    // The watchdog only runs in RUN and restarts from zero on any reset or SW trigger.
    assign w_wdt_clear = i_reset || i_sw_reset_req || (r_state != ST_RUN);

    wdt_counter #(
        .WDT_WIDTH   (WDT_WIDTH),
        .WDT_TIMEOUT (WDT_TIMEOUT)
    ) u_wdt (
        .i_clock  (i_clock),
        .i_clear  (w_wdt_clear),
        .i_enable (i_wdt_enable),
        .i_kick   (i_wdt_kick),
        .o_expire (w_wdt_expire)
    );

    // Sequencer FSM: triggers dominate, otherwise hold, then stagger the releases.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= ST_ASSERT;
            r_hold         <= '0;
            r_stag         <= '0;
            r_idx          <= '0;
            r_domain_reset <= '1;
            r_all_released <= 1'b0;
            r_reset_cause  <= CAUSE_EXT;
            r_reset_count  <= '0;
        end else if (i_sw_reset_req || w_wdt_expire) begin
            // SW wins the cause field when both fire together; counted once.
            r_state        <= ST_ASSERT;
            r_hold         <= '0;
            r_stag         <= '0;
            r_idx          <= '0;
            r_domain_reset <= '1;
            r_all_released <= 1'b0;
            r_reset_cause  <= i_sw_reset_req ? CAUSE_SW : CAUSE_WDT;
            r_reset_count  <= sat_inc(r_reset_count);
        end else begin
            unique case (r_state)
                ST_ASSERT: begin
                    if (r_hold == HOLD_LAST) begin
                        r_hold            <= '0;
                        r_domain_reset[0] <= 1'b0;
                        if (NUM_DOMAINS == 1) begin
                            r_state        <= ST_RUN;
                            r_all_released <= 1'b1;
                        end else begin
                            r_state <= ST_RELEASE;
                            r_stag  <= '0;
                            r_idx   <= IDX_ONE;
                        end
                    end else begin
                        r_hold <= r_hold + HOLD_ONE;
                    end
                end
                ST_RELEASE: begin
                    // r_idx is the next domain to release.
                    if (r_stag == STAG_LAST) begin
                        r_stag                <= '0;
                        r_domain_reset[r_idx] <= 1'b0;
                        if (r_idx == IDX_LAST) begin
                            r_state        <= ST_RUN;
                            r_all_released <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_ONE;
                        end
                    end else begin
                        r_stag <= r_stag + STAG_ONE;
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state        <= ST_ASSERT;
                    r_hold         <= '0;
                    r_domain_reset <= '1;
                    r_all_released <= 1'b0;
                end
            endcase
        end
    end

    assign o_domain_reset = r_domain_reset;
    assign o_all_released = r_all_released;
    assign o_reset_cause  = r_reset_cause;
    assign o_reset_count  = r_reset_count;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer. A behavioural model expressed in
// "edges since the last trigger" drives a scoreboard queue of expected outputs.
module tb_reset_sequencer;

    localparam int N     = 4;
    localparam int PULSE = 4;
    localparam int STAG  = 2;
    localparam int TMO   = 16;
    localparam int FULL  = PULSE + (N - 1) * STAG;

    typedef struct packed {
        logic [3:0] dr;
        logic       ar;
        logic [1:0] cause;
        logic [7:0] cnt;
    } obs_t;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_sw = 1'b0;
    logic       i_en = 1'b0;
    logic       i_kick = 1'b0;
    logic [3:0] o_domain_reset;
    logic       o_all_released;
    logic [1:0] o_reset_cause;
    logic [7:0] o_reset_count;

    reset_sequencer #(
        .NUM_DOMAINS  (N),
        .PULSE_CYCLES (PULSE),
        .STAGGER      (STAG),
        .WDT_WIDTH    (16),
        .WDT_TIMEOUT  (TMO)
    ) dut (
        .i_clock        (clk),
        .i_reset        (i_reset),
        .i_sw_reset_req (i_sw),
        .i_wdt_enable   (i_en),
        .i_wdt_kick     (i_kick),
        .o_domain_reset (o_domain_reset),
        .o_all_released (o_all_released),
        .o_reset_cause  (o_reset_cause),
        .o_reset_count  (o_reset_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: edges since last trigger, watchdog count, cause, count.
    int         m_t = 0;
    int         m_w = 0;
    int         m_cnt = 0;
    logic [1:0] m_cause = 2'b00;
    obs_t       sb_q[$];

    function automatic obs_t model_exp();
        obs_t e;
        for (int k = 0; k < N; k++) e.dr[k] = (m_t < PULSE + k * STAG);
        e.ar    = (m_t >= FULL);
        e.cause = m_cause;
        e.cnt   = 8'(m_cnt);
        return e;
    endfunction

    function automatic obs_t observe();
        return {o_domain_reset, o_all_released, o_reset_cause, o_reset_count};
    endfunction

    // Drive one cycle, push the model's expectation, advance past the edge.
    task automatic step(input logic r, input logic s, input logic e, input logic k);
        logic run;
        logic expire;
        i_reset = r;
        i_sw    = s;
        i_en    = e;
        i_kick  = k;
        run    = (m_t >= FULL);
        expire = run && e && !k && (m_w + 1 == TMO);
        if (r) begin
            m_t = 0; m_w = 0; m_cnt = 0; m_cause = 2'b00;
        end else if (s || expire) begin
            m_t = 0; m_w = 0;
            m_cause = s ? 2'b01 : 2'b10;
            if (m_cnt < 255) m_cnt++;
        end else begin
            if (m_t < 1000) m_t++;
            m_w = (run && e && !k) ? m_w + 1 : 0;
        end
        sb_q.push_back(model_exp());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, g;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front(); g = observe(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, g, e); end
            n_cmp++;
            if (o_domain_reset !== 4'hF) begin
                n_err++; $display("FAIL reset_all_ones got=%h want=f", o_domain_reset);
            end
        end
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front(); g = observe(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL reset_release cyc=%0d got=%h want=%h", i, g, e); end
            if (i == 4 || i == 6 || i == 8 || i == 10) begin
                logic [3:0] want;
                want = (i == 4) ? 4'hE : (i == 6) ? 4'hC : (i == 8) ? 4'h8 : 4'h0;
                n_cmp++;
                if (o_domain_reset !== want) begin
                    n_err++; $display("FAIL release_edge_%0d got=%h want=%h", i, o_domain_reset, want);
                end
            end
        end
        n_cmp++;
        if (o_all_released !== 1'b1 || o_reset_cause !== 2'b00 || o_reset_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_final got ar=%b cause=%b cnt=%0d want 1/00/0",
                     o_all_released, o_reset_cause, o_reset_count);
        end
    endtask

    task automatic test_sw_in_run();
        obs_t e, g;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        e = sb_q.pop_front(); g = observe(); n_cmp++;
        if (g !== e) begin n_err++; $display("FAIL sw_trigger got=%h want=%h", g, e); end
        n_cmp++;
        if (o_domain_reset !== 4'hF || o_reset_cause !== 2'b01 || o_reset_count !== 8'd1) begin
            n_err++;
            $display("FAIL sw_fields got dr=%h cause=%b cnt=%0d want f/01/1",
                     o_domain_reset, o_reset_cause, o_reset_count);
        end
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front(); g = observe(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL sw_release cyc=%0d got=%h want=%h", i, g, e); end
        end
    endtask

    task automatic test_wdt_expiry();
        obs_t e, g;
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            e = sb_q.pop_front(); g = observe(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL wdt_count cyc=%0d got=%h want=%h", i, g, e); end
            if (i == 15) begin
                n_cmp++;
                if (o_domain_reset !== 4'h0) begin
                    n_err++; $display("FAIL wdt_early got=%h want=0", o_domain_reset);
                end
            end
        end
        n_cmp++;
        if (o_domain_reset !== 4'hF || o_reset_cause !== 2'b10 || o_reset_count !== 8'd2) begin
            n_err++;
            $display("FAIL wdt_fields got dr=%h cause=%b cnt=%0d want f/10/2",
                     o_domain_reset, o_reset_cause, o_reset_count);
        end
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front(); g = observe(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL wdt_release cyc=%0d got=%h want=%h", i, g, e); end
        end
    endtask

    task automatic test_kick();
        obs_t e, g;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b0, 1'b1, (i % 10 == 9));
            e = sb_q.pop_front(); g = observe(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL kick_periodic cyc=%0d got=%h want=%h", i, g, e); end
        end
        // Counter is restarted, then kicked exactly on the would-be expiry cycle.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        e = sb_q.pop_front(); g = observe(); n_cmp++;
        if (g !== e) begin n_err++; $display("FAIL kick_restart got=%h want=%h", g, e); end
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b0, 1'b1, (i == 16));
            e = sb_q.pop_front(); g = observe(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL kick_on_expiry cyc=%0d got=%h want=%h", i, g, e); end
        end
        n_cmp++;
        if (o_domain_reset !== 4'h0 || o_all_released !== 1'b1 || o_reset_count !== 8'd2) begin
            n_err++;
            $display("FAIL kick_no_trigger got dr=%h ar=%b cnt=%0d want 0/1/2",
                     o_domain_reset, o_all_released, o_reset_count);
        end
    endtask

    task automatic test_sw_mid_release();
        obs_t e, g;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        e = sb_q.pop_front(); g = observe(); n_cmp++;
        if (g !== e) begin n_err++; $display("FAIL mid_first_sw got=%h want=%h", g, e); end
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front(); g = observe(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL mid_partial cyc=%0d got=%h want=%h", i, g, e); end
        end
        n_cmp++;
        if (o_domain_reset !== 4'hC) begin
            n_err++; $display("FAIL mid_at_c got=%h want=c", o_domain_reset);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        e = sb_q.pop_front(); g = observe(); n_cmp++;
        if (g !== e) begin n_err++; $display("FAIL mid_resw got=%h want=%h", g, e); end
        n_cmp++;
        if (o_domain_reset !== 4'hF || o_reset_count !== 8'd4) begin
            n_err++;
            $display("FAIL mid_reassert got dr=%h cnt=%0d want f/4", o_domain_reset, o_reset_count);
        end
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front(); g = observe(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL mid_rehold cyc=%0d got=%h want=%h", i, g, e); end
        end
        n_cmp++;
        if (o_domain_reset !== 4'hE) begin
            n_err++; $display("FAIL mid_rehold_len got=%h want=e", o_domain_reset);
        end
    endtask

    task automatic test_saturation();
        obs_t e, g;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            e = sb_q.pop_front(); g = observe(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL sat_req cyc=%0d got=%h want=%h", i, g, e); end
        end
        n_cmp++;
        if (o_reset_count !== 8'd255 || o_reset_cause !== 2'b01) begin
            n_err++;
            $display("FAIL sat_value got cnt=%0d cause=%b want 255/01", o_reset_count, o_reset_cause);
        end
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front(); g = observe(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL sat_release cyc=%0d got=%h want=%h", i, g, e); end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        e = sb_q.pop_front(); g = observe(); n_cmp++;
        if (g !== e) begin n_err++; $display("FAIL ext_mid_release got=%h want=%h", g, e); end
        n_cmp++;
        if (o_reset_count !== 8'd0 || o_reset_cause !== 2'b00 || o_domain_reset !== 4'hF) begin
            n_err++;
            $display("FAIL ext_clears got cnt=%0d cause=%b dr=%h want 0/00/f",
                     o_reset_count, o_reset_cause, o_domain_reset);
        end
        for (int i = 1; i <= 11; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front(); g = observe(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL ext_rerelease cyc=%0d got=%h want=%h", i, g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_sw_in_run();
        test_wdt_expiry();
        test_kick();
        test_sw_mid_release();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
